axis_block_mean_subtractor: RTL and testbench
=============================================

Name: axis_block_mean_subtractor

Overview:
- AXIS 1-in/1-out stage that collects a block of 2^BLOCK_SIZE_LOG samples.
- It computes the block mean, then replays every sample minus that mean, in arrival order, with a last flag on the final sample.
- It sits directly downstream of the per-sample stages (substituter, clamper) and upstream of the drain or entropy stage.
- Single internal block buffer: load and emit phases alternate; they are not ping-ponged.

Parameters:
- DATA_WIDTH, 16, input sample width.
- BLOCK_SIZE_LOG, 8, log2 of samples per block; legal range 1..12.
- IS_SIGNED, 0, 1 = input samples are two's complement, 0 = unsigned.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- input_valid  in  1  AXIS input valid.
- input_ready  out  1  AXIS input ready.
- input_data  in  DATA_WIDTH  input sample.
- output_valid  out  1  AXIS output valid.
- output_ready  in  1  AXIS output ready.
- output_data  out  DATA_WIDTH+1  signed two's-complement (sample - mean).
- output_last  out  1  high with the final sample of each block.

Behaviour:
- Reset (async, active-high; takes effect immediately):
  - state=LOAD, sample counter=0, accumulator=0, mean register=0.
  - input_ready=1, output_valid=0, output_last=0, output_data=0.
  - Any partial block is discarded.
- States: LOAD, MEAN, EMIT.
- LOAD:
  - input_ready=1, output_valid=0.
  - On each input handshake: buffer[count]=input_data; acc += input_data (sign-extended if IS_SIGNED, else zero-extended); count++.
  - acc width is DATA_WIDTH+BLOCK_SIZE_LOG, so there is no overflow.
  - The handshake with count = 2^BLOCK_SIZE_LOG-1 moves the state to MEAN.
  - Gaps in input_valid are allowed; nothing changes without a handshake.
- MEAN (exactly one cycle):
  - input_ready=0.
  - mean = acc >> BLOCK_SIZE_LOG: arithmetic shift if IS_SIGNED, logical otherwise, i.e. floor division.
  - mean is registered at DATA_WIDTH bits.
  - acc and count are cleared; buffer read of index 0 is issued; go to EMIT.
- EMIT:
  - input_ready=0 for the whole phase; there is no concurrent loading.
  - output_data = ext(buffer[i]) - ext(mean), both extended to DATA_WIDTH+1 bits (sign-extend if IS_SIGNED, else zero-extend). Result is always representable.
  - Outputs come from a registered output stage plus synchronous buffer read, with a one-entry skid so the stream can stall.
  - Each output handshake advances i. output_last=1 exactly when i = 2^BLOCK_SIZE_LOG-1.
  - After the handshake carrying output_last, go to LOAD and assert input_ready in the next cycle.
- Latency:
  - Last input handshake at edge t: MEAN during cycle t..t+1, output_valid=1 from cycle t+2 at the latest.
  - With output_ready held high, one output per cycle; a block emits in exactly 2^BLOCK_SIZE_LOG cycles.
  - Full block period = 2*2^BLOCK_SIZE_LOG + 2 cycles at best.
- Handshake rules:
  - Once output_valid=1, output_data, output_last and output_valid are held stable until output_ready=1.
  - output_valid never depends combinationally on output_ready.
  - input_ready never depends combinationally on input_valid.
- Boundaries:
  - Backpressure of any length or pattern loses or duplicates no sample.
  - A block of identical values emits all zeros.
  - Counter wrap at 2^BLOCK_SIZE_LOG resets to 0, never overflows into the next block.
  - Reset asserted mid-LOAD or mid-EMIT aborts the block. The first block after release is a fresh one.
- Buffer: 2^BLOCK_SIZE_LOG x DATA_WIDTH, single-port, synchronous read, inferable as block RAM.

Test Plan:
- BLOCK_SIZE_LOG=2, unsigned.
  - Stimulus: inputs 1,2,3,5 (sum 11, mean 2).
  - Required: outputs -1,0,1,3; output_last only on 3; output_valid within 2 cycles of the 4th handshake; input_ready=0 until the 3 is accepted.
- BLOCK_SIZE_LOG=2, IS_SIGNED=1.
  - Stimulus: inputs -4,-3,0,2 (sum -5, floor mean -2).
  - Required: outputs -2,-1,2,4.
- BLOCK_SIZE_LOG=2, unsigned, DATA_WIDTH=16.
  - Stimulus: block 0,0,0,65535 (mean 16383), then block 65535 x4.
  - Required: first block -16383,-16383,-16383,49152 in 17-bit two's complement; second block 0,0,0,0.
- BLOCK_SIZE_LOG=8, unsigned.
  - Stimulus: ramp 0..255 with generator toggling enable (sum 32640, mean 127); output_ready held high.
  - Required: outputs -127..128; 256 consecutive output cycles; last on 128; second identical block follows with identical results.
- Backpressure.
  - Stimulus: same stimulus as scenario 1; output_ready driven by a random 30% duty, plus a 10-cycle hold low while output_valid=1.
  - Required: data and last stable during the stall; exact sequence -1,0,1,3 with no loss or duplication.
- Reset mid-operation.
  - Stimulus: rst pulsed after the 2nd output of a block, then a new block 4,4,4,8 is sent.
  - Required: output_valid=0 immediately on rst; input_ready=1 after release; outputs -1,-1,-1,3 (mean 5).

Source files
------------

// File: rtl/axis_block_mean_subtractor.sv
// -----------------------------------------------------------------------------
// axis_block_mean_subtractor
//
// Collects a block of 2^BLOCK_SIZE_LOG samples from an AXI-Stream input,
// computes the block mean (floor division), then replays every sample minus
// that mean, in arrival order, with output_last on the final sample. A single
// block buffer is used, so the load and emit phases strictly alternate.
//
// Parameters:
//   DATA_WIDTH      input sample width
//   BLOCK_SIZE_LOG  log2 of samples per block (1..12)
//   IS_SIGNED       1 = samples are two's complement, 0 = unsigned
//
// Ports:
//   clk           clock, rising edge
//   rst           asynchronous, active-high reset
//   input_valid   AXIS input valid
//   input_ready   AXIS input ready (high only while loading)
//   input_data    input sample, DATA_WIDTH bits
//   output_valid  AXIS output valid (registered)
//   output_ready  AXIS output ready
//   output_data   signed (sample - mean), DATA_WIDTH+1 bits
//   output_last   high with the final sample of each block
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module axis_block_mean_subtractor #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned BLOCK_SIZE_LOG = 8,
  parameter bit          IS_SIGNED      = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  input_valid,
  output logic                  input_ready,
  input  logic [DATA_WIDTH-1:0] input_data,
  output logic                  output_valid,
  input  logic                  output_ready,
  output logic [DATA_WIDTH:0]   output_data,
  output logic                  output_last
);

  localparam int unsigned DEPTH = 1 << BLOCK_SIZE_LOG;
  localparam int unsigned ACC_W = DATA_WIDTH + BLOCK_SIZE_LOG;

  localparam logic [BLOCK_SIZE_LOG-1:0] LAST_IDX = BLOCK_SIZE_LOG'(DEPTH - 1);
  localparam logic [BLOCK_SIZE_LOG-1:0] IDX_ONE  = BLOCK_SIZE_LOG'(1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_MEAN,
    S_EMIT
  } state_t;

  // Control and accumulation state
  state_t                    r_state;
  logic                      r_in_ready;
  logic [BLOCK_SIZE_LOG-1:0] r_count;
  logic [ACC_W-1:0]          r_acc;
  logic [DATA_WIDTH-1:0]     r_mean;

  // Block buffer and its synchronous read register
  logic [DATA_WIDTH-1:0]     r_mem [DEPTH];
  logic [DATA_WIDTH-1:0]     r_rd_data;

  // Read stage bookkeeping: r_rd_valid marks r_rd_data as holding a sample
  // not yet moved to the output register; it doubles as the skid entry.
  logic                      r_rd_valid;
  logic                      r_rd_last;
  logic                      r_rd_more;
  logic [BLOCK_SIZE_LOG-1:0] r_rd_idx;

  // Registered output stage
  logic                      r_out_valid;
  logic                      r_out_last;
  logic [DATA_WIDTH:0]       r_out_data;

  logic                      w_in_fire;
  logic                      w_out_fire;
  logic                      w_out_load;
  logic                      w_rd_en;
  logic                      w_in_sign;
  logic                      w_rd_sign;
  logic                      w_mean_sign;
  logic [ACC_W-1:0]          w_in_ext;
  logic [DATA_WIDTH:0]       w_diff;

  assign w_in_fire  = input_valid & r_in_ready;
  assign w_out_fire = r_out_valid & output_ready;

  // The output register takes a new sample when it is empty or being drained.
  assign w_out_load = r_rd_valid & (~r_out_valid | output_ready);

  // Index 0 is fetched in MEAN; during EMIT a read is issued only when the
  // read register is free or is being emptied this cycle, so it never
  // overwrites a sample still waiting for the output stage.
  assign w_rd_en = (r_state == S_MEAN) |
                   ((r_state == S_EMIT) & r_rd_more & (~r_rd_valid | w_out_load));

  // Sign bits for extension; forced to zero for unsigned samples.
  assign w_in_sign   = IS_SIGNED & input_data[DATA_WIDTH-1];
  assign w_rd_sign   = IS_SIGNED & r_rd_data[DATA_WIDTH-1];
  assign w_mean_sign = IS_SIGNED & r_mean[DATA_WIDTH-1];

  assign w_in_ext = {{BLOCK_SIZE_LOG{w_in_sign}}, input_data};
  assign w_diff   = {w_rd_sign, r_rd_data} - {w_mean_sign, r_mean};

  // ---------------------------------------------------------------------------
  // Phase FSM, accumulator and mean register
  // ---------------------------------------------------------------------------
  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_LOAD;
      r_in_ready <= 1'b1;
      r_count    <= '0;
      r_acc      <= '0;
      r_mean     <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_in_fire) begin
            r_acc   <= r_acc + w_in_ext;
            r_count <= r_count + IDX_ONE;
            if (r_count == LAST_IDX) begin
              r_state    <= S_MEAN;
              r_in_ready <= 1'b0;
            end
          end
        end
        S_MEAN: begin
          // Dropping the top BLOCK_SIZE_LOG bits of the shifted sum removes
          // exactly the bits where logical and arithmetic shifts differ, so
          // this is floor(acc / 2^BLOCK_SIZE_LOG) for both sample encodings.
          r_mean  <= DATA_WIDTH'(r_acc >> BLOCK_SIZE_LOG);
          r_acc   <= '0;
          r_count <= '0;
          r_state <= S_EMIT;
        end
        S_EMIT: begin
          if (w_out_fire && r_out_last) begin
            r_state    <= S_LOAD;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_LOAD;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Block buffer: single port, writes only in LOAD, reads only in MEAN/EMIT
  // ---------------------------------------------------------------------------
  // NOTE: the buffer and its read register carry no reset so they map onto
  // block RAM; r_rd_valid qualifies the read data instead.
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_mem[r_count] <= input_data;
    end
    if (w_rd_en) begin
      r_rd_data <= r_mem[r_rd_idx];
    end
  end

  // ---------------------------------------------------------------------------
  // Read stage control
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_more  <= 1'b0;
      r_rd_idx   <= '0;
    end else if (w_rd_en) begin
      r_rd_valid <= 1'b1;
      r_rd_last  <= (r_rd_idx == LAST_IDX);
      r_rd_more  <= (r_rd_idx != LAST_IDX);
      r_rd_idx   <= r_rd_idx + IDX_ONE;  // wraps to 0 after the final sample
    end else if (w_out_load) begin
      r_rd_valid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register: holds data/last/valid while stalled
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else if (w_out_load) begin
      r_out_valid <= 1'b1;
      r_out_last  <= r_rd_last;
      r_out_data  <= w_diff;
    end else if (output_ready) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  assign input_ready  = r_in_ready;
  assign output_valid = r_out_valid;
  assign output_data  = r_out_data;
  assign output_last  = r_out_last;

endmodule

// File: tb/tb_axis_block_mean_subtractor.sv
// -----------------------------------------------------------------------------
// tb_axis_block_mean_subtractor
//
// Three instances share one clock:
//   dut 0: BLOCK_SIZE_LOG=2, unsigned  (basic, boundary, backpressure, reset)
//   dut 1: BLOCK_SIZE_LOG=2, signed    (floor mean of a negative sum)
//   dut 2: BLOCK_SIZE_LOG=8, unsigned  (ramp blocks, streaming rate)
// Stimulus pushes hand-computed expected outputs into a per-instance queue;
// a monitor pops and compares on every output handshake and also checks that
// a stalled output holds data/last/valid.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_axis_block_mean_subtractor;

  typedef struct packed {
    logic [16:0] data;
    logic        last;
  } exp_t;

  logic             clk;
  logic             rst_a;
  logic             rst_b;
  logic [2:0]       in_valid;
  logic [2:0]       in_ready;
  logic [2:0][15:0] in_data;
  logic [2:0]       out_valid;
  logic [2:0]       out_ready;
  logic [2:0][16:0] out_data;
  logic [2:0]       out_last;

  int checks = 0;
  int errors = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  axis_block_mean_subtractor #(
    .DATA_WIDTH(16), .BLOCK_SIZE_LOG(2), .IS_SIGNED(1'b0)
  ) u_dut_u2 (
    .clk(clk), .rst(rst_a),
    .input_valid(in_valid[0]), .input_ready(in_ready[0]), .input_data(in_data[0]),
    .output_valid(out_valid[0]), .output_ready(out_ready[0]),
    .output_data(out_data[0]), .output_last(out_last[0])
  );

  axis_block_mean_subtractor #(
    .DATA_WIDTH(16), .BLOCK_SIZE_LOG(2), .IS_SIGNED(1'b1)
  ) u_dut_s2 (
    .clk(clk), .rst(rst_b),
    .input_valid(in_valid[1]), .input_ready(in_ready[1]), .input_data(in_data[1]),
    .output_valid(out_valid[1]), .output_ready(out_ready[1]),
    .output_data(out_data[1]), .output_last(out_last[1])
  );

  axis_block_mean_subtractor #(
    .DATA_WIDTH(16), .BLOCK_SIZE_LOG(8), .IS_SIGNED(1'b0)
  ) u_dut_u8 (
    .clk(clk), .rst(rst_b),
    .input_valid(in_valid[2]), .input_ready(in_ready[2]), .input_data(in_data[2]),
    .output_valid(out_valid[2]), .output_ready(out_ready[2]),
    .output_data(out_data[2]), .output_last(out_last[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int q_size(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic push_exp(input int k, input int v, input bit last);
    exp_t e;
    e.data = v[16:0];
    e.last = last;
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic exp_t pop_exp(input int k);
    case (k)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  // Called at posedge+#1; returns at posedge+#1 just after the handshake edge.
  task automatic send(input int k, input logic [15:0] d);
    bit done;
    done        = 1'b0;
    in_valid[k] = 1'b1;
    in_data[k]  = d;
    for (int n = 0; n < 4000 && !done; n++) begin
      @(negedge clk);
      done = in_ready[k];
      @(posedge clk);
      #1;
    end
    in_valid[k] = 1'b0;
    check($sformatf("send_handshake_d%0d", k), {31'd0, done}, 32'd1);
  endtask

  // Waits until every expected output of instance k has been popped, then
  // steps past the final handshake edge.
  task automatic drain(input int k);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 3000 && !done; n++) begin
      @(negedge clk);
      #1;
      if (q_size(k) == 0) done = 1'b1;
    end
    check($sformatf("drain_d%0d", k), {31'd0, done}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  logic [2:0]       pv = '0;
  logic [2:0]       pr = '0;
  logic [2:0]       pl = '0;
  logic [2:0][16:0] pd = '0;

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (pv[k] && !pr[k]) begin
        check($sformatf("d%0d_stall_valid", k), {31'd0, out_valid[k]}, 32'd1);
        check($sformatf("d%0d_stall_data", k), {15'd0, out_data[k]}, {15'd0, pd[k]});
        check($sformatf("d%0d_stall_last", k), {31'd0, out_last[k]}, {31'd0, pl[k]});
      end
      if (out_valid[k] && out_ready[k]) begin
        if (q_size(k) == 0) begin
          checks++;
          errors++;
          $display("FAIL d%0d_unexpected_output actual=%0h expected=none at %0t",
                   k, out_data[k], $time);
        end else begin
          exp_t e;
          e = pop_exp(k);
          check($sformatf("d%0d_data", k), {15'd0, out_data[k]}, {15'd0, e.data});
          check($sformatf("d%0d_last", k), {31'd0, out_last[k]}, {31'd0, e.last});
        end
      end
      pv[k] = out_valid[k];
      pr[k] = out_ready[k];
      pd[k] = out_data[k];
      pl[k] = out_last[k];
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int  lat;
    int  nvalid;
    bit  seen;
    bit  done;

    rst_a     = 1'b1;
    rst_b     = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 3'b111;

    // Reset state
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_in_ready_d%0d", k), {31'd0, in_ready[k]}, 32'd1);
      check($sformatf("rst_out_valid_d%0d", k), {31'd0, out_valid[k]}, 32'd0);
      check($sformatf("rst_out_last_d%0d", k), {31'd0, out_last[k]}, 32'd0);
      check($sformatf("rst_out_data_d%0d", k), {15'd0, out_data[k]}, 32'd0);
    end
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(posedge clk);
    #1;

    // Scenario 1: 1,2,3,5 -> mean 2 -> -1,0,1,3
    push_exp(0, -1, 1'b0);
    push_exp(0,  0, 1'b0);
    push_exp(0,  1, 1'b0);
    push_exp(0,  3, 1'b1);
    send(0, 16'd1);
    send(0, 16'd2);
    send(0, 16'd3);
    send(0, 16'd5);
    lat = -1;
    for (int c = 0; c < 3 && lat < 0; c++) begin
      @(negedge clk);
      check("s1_in_ready_low_mean", {31'd0, in_ready[0]}, 32'd0);
      if (out_valid[0]) lat = c;
    end
    check("s1_latency_le2", {31'd0, (lat >= 0 && lat <= 2)}, 32'd1);
    done = 1'b0;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      #1;
      check("s1_in_ready_low_emit", {31'd0, in_ready[0]}, 32'd0);
      if (q_size(0) == 0) done = 1'b1;
    end
    check("s1_emit_done", {31'd0, done}, 32'd1);
    @(posedge clk);
    #1;
    check("s1_in_ready_after_last", {31'd0, in_ready[0]}, 32'd1);

    // Scenario 2: signed -4,-3,0,2 -> floor mean -2 -> -2,-1,2,4
    push_exp(1, -2, 1'b0);
    push_exp(1, -1, 1'b0);
    push_exp(1,  2, 1'b0);
    push_exp(1,  4, 1'b1);
    send(1, 16'hFFFC);
    send(1, 16'hFFFD);
    send(1, 16'h0000);
    send(1, 16'h0002);
    drain(1);

    // Scenario 3: extremes, then a constant block
    push_exp(0, -16383, 1'b0);
    push_exp(0, -16383, 1'b0);
    push_exp(0, -16383, 1'b0);
    push_exp(0,  49152, 1'b1);
    send(0, 16'd0);
    send(0, 16'd0);
    send(0, 16'd0);
    send(0, 16'd65535);
    for (int i = 0; i < 4; i++) push_exp(0, 0, (i == 3));
    for (int i = 0; i < 4; i++) send(0, 16'd65535);
    drain(0);

    // Scenario 4: two 256-sample ramps with a toggling input enable
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 256; i++) push_exp(2, i - 127, (i == 255));
      for (int i = 0; i < 256; i++) begin
        send(2, 16'(i));
        if (i % 2 == 1) begin
          @(posedge clk);
          #1;
        end
      end
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
        @(negedge clk);
        seen = out_valid[2];
      end
      check($sformatf("s4_first_valid_b%0d", b), {31'd0, seen}, 32'd1);
      nvalid = 0;
      for (int i = 0; i < 256; i++) begin
        if (out_valid[2]) nvalid++;
        @(negedge clk);
      end
      check($sformatf("s4_consecutive_b%0d", b), nvalid, 32'd256);
      check($sformatf("s4_valid_drop_b%0d", b), {31'd0, out_valid[2]}, 32'd0);
      drain(2);
    end

    // Scenario 5: scenario 1 under backpressure
    out_ready[0] = 1'b0;
    push_exp(0, -1, 1'b0);
    push_exp(0,  0, 1'b0);
    push_exp(0,  1, 1'b0);
    push_exp(0,  3, 1'b1);
    send(0, 16'd1);
    send(0, 16'd2);
    send(0, 16'd3);
    send(0, 16'd5);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = out_valid[0];
    end
    check("s5_valid_seen", {31'd0, seen}, 32'd1);
    repeat (10) @(posedge clk);
    #1;
    done = 1'b0;
    for (int n = 0; n < 1000 && !done; n++) begin
      if (q_size(0) == 0) done = 1'b1;
      else begin
        out_ready[0] = ($urandom_range(0, 99) < 30);
        @(posedge clk);
        #1;
      end
    end
    check("s5_drained", {31'd0, done}, 32'd1);
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;

    // Scenario 6: reset after the 2nd output, then a fresh block 4,4,4,8
    push_exp(0, -1, 1'b0);
    push_exp(0,  0, 1'b0);
    send(0, 16'd1);
    send(0, 16'd2);
    send(0, 16'd3);
    send(0, 16'd5);
    done = 1'b0;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      #1;
      if (q_size(0) == 0) done = 1'b1;
    end
    check("s6_two_outputs", {31'd0, done}, 32'd1);
    @(posedge clk);
    #1;
    rst_a = 1'b1;
    #1;
    check("s6_rst_out_valid", {31'd0, out_valid[0]}, 32'd0);
    check("s6_rst_out_last", {31'd0, out_last[0]}, 32'd0);
    @(negedge clk);
    rst_a = 1'b0;
    @(posedge clk);
    #1;
    check("s6_in_ready_after_rst", {31'd0, in_ready[0]}, 32'd1);
    push_exp(0, -1, 1'b0);
    push_exp(0, -1, 1'b0);
    push_exp(0, -1, 1'b0);
    push_exp(0,  3, 1'b1);
    send(0, 16'd4);
    send(0, 16'd4);
    send(0, 16'd4);
    send(0, 16'd8);
    drain(0);

    repeat (5) @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("final_queue_empty_d%0d", k), q_size(k), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
